uart_bus_ctrl: RTL and testbench

Memory-mapped UART controller between the single-cycle MIPS CPU's peripheral bus (rd/wr/addr/wdata/rdata) and the byte-level UART transceiver core. It buffers outgoing bytes in a small TX FIFO and launches them to the transmitter one at a time. It holds one received byte with overrun detection and raises an interrupt request toward the CPU on enabled TX/RX events.

---
 rtl/uart_bus_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_ctrl
// Brief    : CPU-bus UART controller with TX FIFO/launcher, RX holding
//            register with overrun detect, and level interrupt request.
// Revision : 1.0
// ============================================================================
module uart_bus_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD   = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD   = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON   = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_status,
  input  logic [7:0]  rx_data,
  input  logic        rx_end,
  output logic        irqout
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LAUNCH     = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [7:0]         r_tx_last;
  logic [7:0]         r_rx_buf;
  logic               r_rx_valid, r_rx_ovr, r_tx_drop;
  logic               r_tx_irq_en, r_rx_irq_en;

  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_push_req, w_push, w_pop, w_full, w_empty, w_drop;
  logic w_rxd_rd, w_con_wr, w_rx_ovr_set, w_rx_load, w_tx_busy;
  logic [7:0] w_head;
  logic w_unused_bits;

  assign w_sel_txd = (addr == ADDR_TXD);
  assign w_sel_rxd = (addr == ADDR_RXD);
  assign w_sel_con = (addr == ADDR_CON);

  assign w_full     = (r_count == c_FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_pop      = (r_state == S_LAUNCH);
  assign w_push_req = wr & w_sel_txd;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_head     = r_mem[r_rd_ptr];

  assign w_rxd_rd     = rd & w_sel_rxd;
  assign w_con_wr     = wr & w_sel_con;
  assign w_rx_ovr_set = rx_end & r_rx_valid & ~w_rxd_rd;
  assign w_rx_load    = rx_end & ~w_rx_ovr_set;
  assign w_tx_busy    = (r_state != S_IDLE) | ~w_empty;

  assign w_unused_bits = ^wdata[31:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_last <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
        r_tx_last <= w_head;
      end
      if (w_push && !w_pop)      r_count <= r_count + (c_PTR_W+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (c_PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (!w_empty && !tx_status) w_state_nxt = S_LAUNCH;
      S_LAUNCH:     w_state_nxt = S_WAIT_START;
      S_WAIT_START: if (tx_status) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:  if (!tx_status) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_en   = (r_state == S_LAUNCH);
  assign tx_data = tx_en ? w_head : r_tx_last;

  // Sticky flags: a new set event in the same cycle beats a software clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_buf    <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_drop   <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_rx_irq_en <= 1'b0;
    end else begin
      if (w_rx_load)     r_rx_buf <= rx_data;
      if (w_rx_load)     r_rx_valid <= 1'b1;
      else if (w_rxd_rd) r_rx_valid <= 1'b0;
      r_rx_ovr  <= w_rx_ovr_set | (r_rx_ovr & ~(w_con_wr & wdata[5]));
      r_tx_drop <= w_drop | (r_tx_drop & ~(w_con_wr & wdata[6]));
      if (w_con_wr) begin
        r_tx_irq_en <= wdata[0];
        r_rx_irq_en <= wdata[1];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (w_sel_rxd)
        rdata = {24'b0, r_rx_buf};
      else if (w_sel_con)
        rdata = {25'b0, r_tx_drop, r_rx_ovr, w_tx_busy, r_rx_valid,
                 w_full, r_rx_irq_en, r_tx_irq_en};
    end
  end

  assign irqout = (r_tx_irq_en & w_empty & (r_state == S_IDLE)) |
                  (r_rx_irq_en & r_rx_valid);

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_ctrl
// Brief    : Scoreboard bench for uart_bus_ctrl: directed bus/RX/TX vectors.
// Revision : 1.0
// ============================================================================
module tb_uart_bus_ctrl;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_status = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_end = 1'b0;
  logic        irqout;

  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  bit   tx_auto = 1'b0;
  logic prev_tx_en = 1'b0;

  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] mon_exp;
  string       mon_nm;
  logic [7:0]  mon_tx;

  always #5 clk = ~clk;

  uart_bus_ctrl #(
    .FIFO_DEPTH(4),
    .ADDR_TXD  (A_TXD),
    .ADDR_RXD  (A_RXD),
    .ADDR_CON  (A_CON)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_status(tx_status),
    .rx_data  (rx_data),
    .rx_end   (rx_end),
    .irqout   (irqout)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected read data and launched bytes as the DUT presents them.
  initial forever begin
    @(negedge clk);
    if (rd) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected no read", rdata);
      end else begin
        mon_exp = rd_q.pop_front();
        mon_nm  = rd_name_q.pop_front();
        check(mon_nm, rdata, mon_exp);
      end
    end
    if (tx_en) begin
      pulses++;
      check("tx_en_single_cycle", {31'b0, prev_tx_en}, 32'h0);
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got %h expected no launch", tx_data);
      end else begin
        mon_tx = tx_q.pop_front();
        check("tx_data", {24'b0, tx_data}, {24'b0, mon_tx});
      end
    end
    prev_tx_en = tx_en;
  end

  // Transmitter model: busy for 10 cycles after each launch when enabled.
  initial forever begin
    @(negedge clk);
    if (tx_auto && tx_en) begin
      tx_status = 1'b1;
      repeat (10) @(negedge clk);
      tx_status = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    rd_q.push_back(exp); rd_name_q.push_back(nm);
    @(posedge clk); #1;
    rd = 1'b0; addr = '0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(posedge clk); #1;
    rx_end = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_end = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input string nm);
    int k = 0;
    while (pulses < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(nm, {31'b0, pulses >= n}, 32'h1);
  endtask

  initial begin
    int p0;
    int cyc;

    // Reset held: idle outputs and a CON read of zero.
    bus_read(A_CON, 32'h0, "con_in_reset");
    @(negedge clk);
    check("irq_in_reset", {31'b0, irqout}, 32'h0);
    check("tx_en_in_reset", {31'b0, tx_en}, 32'h0);
    check("tx_data_in_reset", {24'b0, tx_data}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    bus_read(A_CON, 32'h0, "con_after_reset");
    bus_read(A_RXD, 32'h0, "rxd_after_reset");
    bus_read(A_TXD, 32'h0, "txd_read_zero");
    bus_read(32'h4000_0024, 32'h0, "unmapped_read");

    // Two frames in order, busy until the second ends.
    tx_auto = 1'b1;
    p0 = pulses;
    tx_q.push_back(8'h41); bus_write(A_TXD, 32'h41);
    tx_q.push_back(8'h42); bus_write(A_TXD, 32'h42);
    bus_read(A_CON, 32'h10, "busy_after_writes");
    wait_pulses(p0 + 2, "two_launches");
    repeat (4) @(negedge clk);
    bus_read(A_CON, 32'h10, "busy_second_frame");
    repeat (15) @(negedge clk);
    bus_read(A_CON, 32'h0, "idle_after_frames");
    check("pulse_count_two", pulses - p0, 32'd2);

    // Overflow with transmitter held busy; fifth byte dropped.
    tx_auto = 1'b0;
    @(posedge clk); #1 tx_status = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_q.push_back(8'hA0 + 8'(i));
      bus_write(A_TXD, 32'hA0 + i);
    end
    bus_write(32'h4000_0030, 32'h0000_0003);
    bus_read(A_CON, 32'h54, "full_drop_busy");
    bus_write(A_CON, 32'h40);
    bus_read(A_CON, 32'h14, "drop_cleared");
    p0 = pulses;
    @(posedge clk); #1;
    tx_status = 1'b0; tx_auto = 1'b1;
    wait_pulses(p0 + 4, "four_launches");
    repeat (20) @(negedge clk);
    bus_read(A_CON, 32'h0, "idle_after_overflow");
    check("pulse_count_four", pulses - p0, 32'd4);

    // RX single byte with interrupt.
    bus_write(A_CON, 32'h02);
    rx_pulse(8'h5A);
    @(negedge clk);
    check("rx_irq_high", {31'b0, irqout}, 32'h1);
    bus_read(A_RXD, 32'h5A, "rxd_5a");
    @(negedge clk);
    check("rx_irq_low", {31'b0, irqout}, 32'h0);
    bus_read(A_CON, 32'h02, "rx_valid_cleared");

    // Overrun: first byte kept, sticky flag set, then cleared by write-1.
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    bus_read(A_RXD, 32'h11, "rxd_kept_11");
    bus_read(A_CON, 32'h22, "overrun_set");
    bus_write(A_CON, 32'h22);
    bus_read(A_CON, 32'h02, "overrun_cleared");

    // Read coincident with the second byte: new byte loads, no overrun.
    rx_pulse(8'h11);
    @(posedge clk); #1;
    rd = 1'b1; addr = A_RXD; rx_end = 1'b1; rx_data = 8'h22;
    rd_q.push_back(32'h11); rd_name_q.push_back("rxd_same_cycle");
    @(posedge clk); #1;
    rd = 1'b0; addr = '0; rx_end = 1'b0;
    bus_read(A_CON, 32'h0A, "no_overrun_valid");
    bus_read(A_RXD, 32'h22, "rxd_22");
    bus_read(A_CON, 32'h02, "rx_drained");

    // TX interrupt: high when idle, low while sending, back high afterwards.
    bus_write(A_CON, 32'h01);
    @(negedge clk);
    check("tx_irq_idle", {31'b0, irqout}, 32'h1);
    p0 = pulses;
    tx_q.push_back(8'h77);
    bus_write(A_TXD, 32'h77);
    @(negedge clk);
    check("tx_irq_drop", {31'b0, irqout}, 32'h0);
    wait_pulses(p0 + 1, "irq_launch");
    @(negedge clk);
    check("tx_irq_mid_frame", {31'b0, irqout}, 32'h0);
    cyc = 0;
    while (irqout !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("tx_irq_return", {31'b0, irqout}, 32'h1);
    check("tx_irq_not_early", {31'b0, cyc >= 8}, 32'h1);

    // Reset mid-frame: outputs return to reset values, queued byte lost.
    p0 = pulses;
    tx_q.push_back(8'h88);
    bus_write(A_TXD, 32'h88);
    bus_write(A_TXD, 32'h99);
    wait_pulses(p0 + 1, "pre_reset_launch");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_tx_en", {31'b0, tx_en}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_irq", {31'b0, irqout}, 32'h0);
    bus_read(A_CON, 32'h0, "con_mid_reset");
    @(posedge clk); #1 reset = 1'b1;
    repeat (40) @(negedge clk);
    check("no_launch_after_reset", pulses - p0, 32'd1);
    bus_read(A_CON, 32'h0, "con_after_abort");

    @(negedge clk);
    check("rd_q_drained", rd_q.size(), 32'd0);
    check("tx_q_drained", tx_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
